// File: rtl/rvfi_commit_tracker_pkg.sv
// rvfi_tracker_pkg
// Shared types and helpers for the RVFI commit tracker.
//   tracker_state_e : FSM encoding, also exported on state_o
//   GOOD_MAGIC      : default pass pattern written by test programs
//   FAIL_MAGIC      : default fail pattern written by test programs
//   popcount        : ones count over up to MAX_LANES commit bits
package rvfi_tracker_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } tracker_state_e;

    localparam logic [31:0] GOOD_MAGIC = 32'h600D600D;
    localparam logic [31:0] FAIL_MAGIC = 32'h0000000F;

    localparam int MAX_LANES = 4;

    function automatic logic [2:0] popcount(input logic [MAX_LANES-1:0] bits);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + {2'b00, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rvfi_commit_tracker_if.sv
// rvfi_commit_tracker_if
// Bundles the commit request side and the RVFI result side of the tracker.
//   commit_valid   : per-lane retire request, lane 0 oldest
//   commit_stall   : global stall
//   watch_data     : packed watched register values
//   commit_o       : effective commit per lane
//   order_o        : packed order number per lane
//   commit_count_o : total effective commits
//   halt_o         : sticky halt
//   timeout_o      : sticky watchdog trip
//   state_o        : FSM state for debug
// master = the side driving requests, slave = the tracker.
interface rvfi_commit_tracker_if #(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = 32,
    parameter int NUM_WATCH = 2,
    parameter int ORDER_W   = 64
);
    logic [NUM_LANES-1:0]         commit_valid;
    logic                         commit_stall;
    logic [NUM_WATCH*XLEN-1:0]    watch_data;
    logic [NUM_LANES-1:0]         commit_o;
    logic [NUM_LANES*ORDER_W-1:0] order_o;
    logic [ORDER_W-1:0]           commit_count_o;
    logic                         halt_o;
    logic                         timeout_o;
    logic [1:0]                   state_o;

    modport master (
        output commit_valid, commit_stall, watch_data,
        input  commit_o, order_o, commit_count_o, halt_o, timeout_o, state_o
    );

    modport slave (
        input  commit_valid, commit_stall, watch_data,
        output commit_o, order_o, commit_count_o, halt_o, timeout_o, state_o
    );
endinterface

// File: rtl/rvfi_commit_tracker_lane_order_gen.sv
// lane_order_gen
// Combinational order numbering: each lane gets base plus the number of
// effective commits in the older (lower-index) lanes.
//   base   : order number of the first commit this cycle
//   commit : effective commit per lane
//   order  : packed order number per lane
module lane_order_gen
    import rvfi_tracker_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int ORDER_W   = 64
) (
    input  logic [ORDER_W-1:0]           base,
    input  logic [NUM_LANES-1:0]         commit,
    output logic [NUM_LANES*ORDER_W-1:0] order
);
    logic [MAX_LANES-1:0] commit_ext;

    assign commit_ext = MAX_LANES'(commit);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        // Keep only the lanes older than lane i.
        localparam logic [MAX_LANES-1:0] OLDER = MAX_LANES'((1 << i) - 1);
        assign order[i*ORDER_W +: ORDER_W] = base + ORDER_W'(popcount(commit_ext & OLDER));
    end
endmodule

// File: rtl/rvfi_commit_tracker.sv
// rvfi_commit_tracker
// Multi-lane RVFI commit/order tracker with sticky halt detection on magic
// register values, a post-halt drain window and an optional idle watchdog.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : rvfi_commit_tracker_if.slave (requests in, commit/order/halt out)
// Optional feature macro: RVFI_WATCHDOG_EN enables the idle counter, the
// TIMEOUT state and timeout_o. Without it timeout_o is tied low.
//
// state   | meaning
// RUN     | normal retire, watching for a halt pattern
// DRAIN   | halt seen, commits still counted for HALT_DRAIN cycles
// HALTED  | terminal, all commits blocked
// TIMEOUT | terminal, watchdog tripped, all commits blocked
module rvfi_commit_tracker
    import rvfi_tracker_pkg::*;
#(
    parameter int               NUM_LANES      = 2,
    parameter int               XLEN           = 32,
    parameter int               NUM_WATCH      = 2,
    parameter int               ORDER_W        = 64,
    parameter logic [XLEN-1:0]  HALT_MAGIC0    = XLEN'(GOOD_MAGIC),
    parameter logic [XLEN-1:0]  HALT_MAGIC1    = XLEN'(FAIL_MAGIC),
    parameter int               HALT_DRAIN     = 4,
    parameter int               TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    rvfi_commit_tracker_if.slave  bus
);
    localparam int DRAIN_W = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;

    tracker_state_e       state, state_nxt;
    logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_nxt;
    logic [ORDER_W-1:0]   base;
    logic [NUM_LANES-1:0] commit;
    logic                 match;
    logic                 idle_trip;
    logic                 halt_q;

    // rst is folded in so commit_o reads 0 throughout reset.
    assign commit = bus.commit_valid &
                    {NUM_LANES{~bus.commit_stall & ~rst & ((state == RUN) || (state == DRAIN))}};

    always_comb begin
        match = 1'b0;
        for (int w = 0; w < NUM_WATCH; w++) begin
            if ((bus.watch_data[w*XLEN +: XLEN] == HALT_MAGIC0) ||
                (bus.watch_data[w*XLEN +: XLEN] == HALT_MAGIC1)) begin
                match = 1'b1;
            end
        end
    end

`ifdef RVFI_WATCHDOG_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state == RUN) begin
            if (|commit) begin
                idle_cnt <= '0;
            end else if (idle_cnt != '1) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    assign idle_trip = (state == RUN) && !(|commit) &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign idle_trip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            RUN: begin
                // A halt match takes priority over a simultaneous watchdog trip.
                if (match) begin
                    if (HALT_DRAIN == 0) begin
                        state_nxt = HALTED;
                    end else begin
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = DRAIN_W'(HALT_DRAIN - 1);
                    end
                end else if (idle_trip) begin
                    state_nxt = TIMEOUT;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = HALTED;
                end else begin
                    drain_cnt_nxt = drain_cnt - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base   <= '0;
            halt_q <= 1'b0;
        end else begin
            base   <= base + ORDER_W'(popcount(MAX_LANES'(commit)));
            halt_q <= (state == HALTED) || (state == TIMEOUT);
        end
    end

`ifdef RVFI_WATCHDOG_EN
    logic timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == TIMEOUT);
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign bus.timeout_o = 1'b0;
`endif

    lane_order_gen #(
        .NUM_LANES (NUM_LANES),
        .ORDER_W   (ORDER_W)
    ) u_lane_order_gen (
        .base   (base),
        .commit (commit),
        .order  (bus.order_o)
    );

    assign bus.commit_o       = commit;
    assign bus.commit_count_o = base;
    assign bus.halt_o         = halt_q;
    assign bus.state_o        = state;
endmodule

// File: tb/tb_rvfi_commit_tracker.sv
module tb_rvfi_commit_tracker;
    logic clk;
    logic rst;
    logic rst_s;
    int   n_cmp;
    int   n_err;

    rvfi_commit_tracker_if m_if ();
    rvfi_commit_tracker_if #(.ORDER_W(4)) s_if ();

    rvfi_commit_tracker u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    rvfi_commit_tracker #(
        .ORDER_W        (4),
        .HALT_DRAIN     (0),
        .TIMEOUT_CYCLES (10)
    ) u_small (
        .clk (clk),
        .rst (rst_s),
        .bus (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        rst_s = 1'b1;
        m_if.commit_valid = 2'b11;
        m_if.commit_stall = 1'b0;
        m_if.watch_data   = '0;
        s_if.commit_valid = 2'b00;
        s_if.commit_stall = 1'b0;
        s_if.watch_data   = '0;

        // Reset state
        #3;
        check("rst_commit", 64'(m_if.commit_o), 64'h0);
        check("rst_count", m_if.commit_count_o, 64'h0);
        check("rst_halt", 64'(m_if.halt_o), 64'h0);
        check("rst_timeout", 64'(m_if.timeout_o), 64'h0);
        check("rst_state", 64'(m_if.state_o), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Dual commits for three cycles
        #1;
        check("c0_commit", 64'(m_if.commit_o), 64'h3);
        check("c0_ord0", m_if.order_o[63:0], 64'd0);
        check("c0_ord1", m_if.order_o[127:64], 64'd1);
        tick();
        check("c1_ord0", m_if.order_o[63:0], 64'd2);
        check("c1_ord1", m_if.order_o[127:64], 64'd3);
        tick();
        check("c2_ord0", m_if.order_o[63:0], 64'd4);
        check("c2_ord1", m_if.order_o[127:64], 64'd5);
        tick();
        m_if.commit_valid = 2'b01;
        #1;
        check("count6", m_if.commit_count_o, 64'd6);
        tick();

        // Non-contiguous valid at base 7
        m_if.commit_valid = 2'b10;
        #1;
        check("gap_count", m_if.commit_count_o, 64'd7);
        check("gap_commit", 64'(m_if.commit_o), 64'h2);
        check("gap_ord1", m_if.order_o[127:64], 64'd7);
        tick();
        check("gap_next", m_if.commit_count_o, 64'd8);

        // Global stall
        m_if.commit_valid = 2'b11;
        m_if.commit_stall = 1'b1;
        #1;
        check("stall_commit", 64'(m_if.commit_o), 64'h0);
        tick();
        check("stall_count", m_if.commit_count_o, 64'd8);
        m_if.commit_stall = 1'b0;

        // Halt with 4-cycle drain; commits continue through the drain
        m_if.watch_data[31:0] = 32'h600D600D;
        #1;
        check("t_state", 64'(m_if.state_o), 64'd0);
        tick();
        m_if.watch_data = '0;
        #1;
        check("t1_state", 64'(m_if.state_o), 64'd1);
        check("t1_count", m_if.commit_count_o, 64'd10);
        tick();
        tick();
        tick();
        check("t4_state", 64'(m_if.state_o), 64'd1);
        tick();
        check("t5_state", 64'(m_if.state_o), 64'd2);
        check("t5_halt", 64'(m_if.halt_o), 64'h0);
        check("t5_commit", 64'(m_if.commit_o), 64'h0);
        tick();
        check("t6_halt", 64'(m_if.halt_o), 64'h1);
        check("t6_timeout", 64'(m_if.timeout_o), 64'h0);
        check("t6_count", m_if.commit_count_o, 64'd18);
        tick();
        check("t7_count", m_if.commit_count_o, 64'd18);

        // Async reset clears the halted tracker
        rst = 1'b1;
        #1;
        check("arst_halt", 64'(m_if.halt_o), 64'h0);
        check("arst_state", 64'(m_if.state_o), 64'd0);
        check("arst_count", m_if.commit_count_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a drain
        m_if.watch_data[63:32] = 32'h0000000F;
        tick();
        m_if.watch_data = '0;
        tick();
        check("md_state", 64'(m_if.state_o), 64'd1);
        check("md_count", m_if.commit_count_o, 64'd4);
        rst = 1'b1;
        #1;
        check("md_rst_state", 64'(m_if.state_o), 64'd0);
        check("md_rst_count", m_if.commit_count_o, 64'd0);
        check("md_rst_commit", 64'(m_if.commit_o), 64'h0);
        check("md_rst_halt", 64'(m_if.halt_o), 64'h0);
        m_if.commit_valid = 2'b00;

        // Narrow order counter wrap on the small instance
        @(negedge clk);
        rst_s = 1'b0;
        s_if.commit_valid = 2'b11;
        for (int i = 0; i < 7; i++) tick();
        s_if.commit_valid = 2'b01;
        tick();
        s_if.commit_valid = 2'b11;
        #1;
        check("wrap_base", 64'(s_if.commit_count_o), 64'd15);
        check("wrap_ord0", 64'(s_if.order_o[3:0]), 64'd15);
        check("wrap_ord1", 64'(s_if.order_o[7:4]), 64'd0);
        tick();
        s_if.commit_valid = 2'b00;
        #1;
        check("wrap_next", 64'(s_if.commit_count_o), 64'd1);

        // Idle watchdog: 10 commit-free cycles trips it
        for (int i = 0; i < 9; i++) tick();
        check("wd_c9_state", 64'(s_if.state_o), 64'd0);
        tick();
        tick();
        s_if.commit_valid = 2'b11;
        #1;
`ifdef RVFI_WATCHDOG_EN
        check("wd_state", 64'(s_if.state_o), 64'd3);
        check("wd_timeout", 64'(s_if.timeout_o), 64'h1);
        check("wd_halt", 64'(s_if.halt_o), 64'h1);
        check("wd_commit", 64'(s_if.commit_o), 64'h0);
`else
        check("wd_state", 64'(s_if.state_o), 64'd0);
        check("wd_timeout", 64'(s_if.timeout_o), 64'h0);
        check("wd_halt", 64'(s_if.halt_o), 64'h0);
        check("wd_commit", 64'(s_if.commit_o), 64'h3);
`endif
        s_if.commit_valid = 2'b00;

        // Zero drain goes straight to HALTED
        rst_s = 1'b1;
        #1;
        check("s_rst_state", 64'(s_if.state_o), 64'd0);
        @(negedge clk);
        rst_s = 1'b0;
        s_if.watch_data[31:0] = 32'h600D600D;
        tick();
        s_if.watch_data = '0;
        #1;
        check("d0_state", 64'(s_if.state_o), 64'd2);
        check("d0_halt_pre", 64'(s_if.halt_o), 64'h0);
        tick();
        check("d0_halt", 64'(s_if.halt_o), 64'h1);
        check("d0_timeout", 64'(s_if.timeout_o), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
